cpu_trap_seq: RTL and testbench
===============================

Name: cpu_trap_seq

Overview:
- Sequences interrupt and exception entry for the pipelined CPU.
- Owns the single register-file write port. It arbitrates between normal WB-stage writes and the trap link write (return address into $26 or $31).
- Drains the pipeline, then redirects fetch to the kernel vector.
- Sits between the WB stage, the register file write port and the PC-select logic.

Parameters:
- DRAIN_CYC, 2, cycles the MEM/WB stages need to retire before the link write.
- LINK_EXC, 5'd26, link register for exceptions.
- LINK_IRQ, 5'd31, link register for interrupts.
- VEC_EXC, 32'h8000_0004, exception vector.
- VEC_IRQ, 32'h8000_0008, interrupt vector.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- irq  in  1  level interrupt request.
- exc_req  in  1  one-cycle exception pulse from ID (illegal opcode).
- epc  in  32  PC of the faulting / interrupted instruction.
- pc_kernel  in  1  PC[31] of the current instruction; 1 = kernel mode.
- wb_we  in  1  WB-stage write enable.
- wb_addr  in  5  WB-stage destination register.
- wb_wdata  in  32  WB-stage write data.
- rf_we  out  1  register-file write enable.
- rf_addr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- stall  out  1  freeze IF/ID while a trap is in progress.
- flush  out  1  one-cycle pulse that kills IF/ID/EX.
- pc_redirect  out  1  one-cycle pulse: load pc_target into the PC.
- pc_target  out  32  vector address.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, reset=0):
  - FSM goes to IDLE; irq_pend, cause and drain counter clear; epc_q = 0.
  - stall, flush, pc_redirect, busy and pc_target are 0.
  - rf_we is forced 0 while reset is low.
  - Reset mid-trap abandons the trap: no link write, no redirect.
- irq_pend is set on any cycle with irq=1. It is cleared only when an IRQ trap is accepted.
- Trap accept happens only in IDLE with pc_kernel=0:
  - exc_req=1 → cause=EXC.
  - Otherwise irq_pend=1 → cause=IRQ.
  - Exception has priority; a simultaneous IRQ stays pending.
  - exc_req while pc_kernel=1 is dropped. IRQ while pc_kernel=1 stays pending.
- On accept:
  - epc_q <= epc; cause latched; drain counter <= DRAIN_CYC-1.
  - flush=1 for that cycle; go to DRAIN.
- FSM states and transitions:
  - IDLE: stall=0.
  - DRAIN: stall=1. Counter decrements each cycle; at 0 go to LINK. Total DRAIN_CYC cycles.
  - LINK: stall=1.
    - If wb_we=1 and wb_addr!=0 this cycle, the WB write wins and the FSM stays in LINK.
    - Otherwise issue the link write: rf_we=1, rf_addr = LINK_EXC or LINK_IRQ by cause, rf_wdata = epc_q+4 (32-bit, wraps modulo 2^32). Go to VECTOR.
  - VECTOR: stall=1, pc_redirect=1, pc_target = VEC_EXC or VEC_IRQ by cause. Go to IDLE.
  - pc_target holds its value after VECTOR until the next redirect.
- Write port mux (combinational):
  - Default: rf_we = wb_we & (wb_addr!=0), rf_addr = wb_addr, rf_wdata = wb_wdata.
  - The link write overrides the default only in the LINK issue cycle.
  - Writes to $0 are never issued.
- Minimum trap latency, accept to redirect, with no WB conflict: DRAIN_CYC+2 cycles.
- busy=1 in DRAIN, LINK and VECTOR.
- A new trap cannot be accepted in the VECTOR→IDLE cycle, because pc_kernel has not yet updated. The next accept happens only once IDLE is reached and pc_kernel=0.

Decomposition:
- Package cpu_trap_pkg holds:
  - state encoding: IDLE=2'd0, DRAIN=2'd1, LINK=2'd2, VECTOR=2'd3;
  - cause encoding: EXC=1'b0, IRQ=1'b1;
  - default vector and link-register constants, shared with the PC-select and decode logic.
- No sub-module: the FSM, drain counter and write mux fit in one module.

Test Plan:
- User mode, epc=32'h0000_0040, exc_req pulse, DRAIN_CYC=2, wb_we=0:
  - flush at cycle 0;
  - rf write $26 = 32'h0000_0044 at cycle 3;
  - pc_redirect with pc_target=32'h8000_0004 at cycle 4.
- irq=1 for 1 cycle, epc=32'h0000_0100, user mode → $31 = 32'h0000_0104, pc_target=32'h8000_0008.
- exc_req and irq in the same cycle:
  - exception trap taken first;
  - the IRQ trap starts only after pc_kernel returns to 0, with $31 = its epc+4.
- pc_kernel=1:
  - exc_req is ignored, with no flush;
  - irq is held pending, and the trap starts on the first IDLE cycle with pc_kernel=0.
- LINK conflict: wb_we=1, wb_addr=5'd8, wb_wdata=32'hDEAD_BEEF during LINK:
  - $8 is written that cycle;
  - the link write is delayed one cycle;
  - the redirect is delayed one cycle.
- Edge cases:
  - reset asserted during DRAIN: all outputs go to 0, there is no link write, and the next irq trap works normally;
  - wb_addr=0 with wb_we=1: rf_we stays 0;
  - epc=32'hFFFF_FFFC: link value = 32'h0000_0000.

Source files
------------

// File: rtl/cpu_trap_pkg.sv
// Shared definitions for trap sequencing.
// Holds the trap FSM state encoding, the trap cause encoding, and the
// default vector and link-register constants. The PC-select and decode
// logic use the same constants.
package cpu_trap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    LINK   = 2'd2,
    VECTOR = 2'd3
  } trap_state_t;

  typedef enum logic {
    EXC = 1'b0,
    IRQ = 1'b1
  } trap_cause_t;

  localparam int          DEF_DRAIN_CYC = 2;
  localparam logic [4:0]  DEF_LINK_EXC  = 5'd26;
  localparam logic [4:0]  DEF_LINK_IRQ  = 5'd31;
  localparam logic [31:0] DEF_VEC_EXC   = 32'h8000_0004;
  localparam logic [31:0] DEF_VEC_IRQ   = 32'h8000_0008;

  // Return address saved in the link register. It wraps modulo 2^32.
  function automatic logic [31:0] link_value(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/cpu_trap_seq.sv
// Interrupt / exception entry sequencer.
// Owns the single register-file write port. It drains MEM/WB, writes the
// return address (epc+4) into the link register, then redirects fetch to
// the kernel vector.
//
// Ports:
//   clk, reset       clock; asynchronous active-low reset
//   irq              level interrupt request (latched into a pending flag)
//   exc_req          one-cycle illegal-opcode pulse from ID
//   epc              PC of the faulting / interrupted instruction
//   pc_kernel        PC[31] of the current instruction (1 = kernel mode)
//   wb_we/addr/wdata WB-stage write request
//   rf_we/addr/wdata register-file write port
//   stall            freezes IF/ID while a trap is in progress
//   flush            one-cycle pulse on trap accept, kills IF/ID/EX
//   pc_redirect      one-cycle pulse: load pc_target into the PC
//   pc_target        vector address, held until the next redirect
//   busy             FSM not in IDLE
//   dbg_state        current FSM state
//
// Handshake: there is no valid/ready pair. A trap is accepted in the cycle
// where the FSM is IDLE, pc_kernel=0, and either exc_req or the pending IRQ
// flag is set. The WB write request is always honoured in the cycle it is
// presented (unless it targets $0). A trap link write only takes the port
// in a cycle with no competing WB write.
module cpu_trap_seq
  import cpu_trap_pkg::*;
#(
  parameter int          DRAIN_CYC = DEF_DRAIN_CYC,
  parameter logic [4:0]  LINK_EXC  = DEF_LINK_EXC,
  parameter logic [4:0]  LINK_IRQ  = DEF_LINK_IRQ,
  parameter logic [31:0] VEC_EXC   = DEF_VEC_EXC,
  parameter logic [31:0] VEC_IRQ   = DEF_VEC_IRQ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        exc_req,
  input  logic [31:0] epc,
  input  logic        pc_kernel,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  trap_state_t       r_state;
  trap_state_t       w_state_nxt;
  trap_cause_t       r_cause;
  trap_cause_t       w_cause_new;
  logic              r_irq_pend;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_epc_q;
  logic [31:0]       r_pc_target;
  logic              w_accept;
  logic              w_wb_hit;
  logic [31:0]       w_vec;

  // Reset is folded in so that no flush can appear while reset is held.
  assign w_accept    = reset & (r_state == IDLE) & ~pc_kernel & (exc_req | r_irq_pend);
  assign w_cause_new = exc_req ? EXC : IRQ;
  assign w_wb_hit    = wb_we & (wb_addr != 5'd0);
  assign w_vec       = (r_cause == IRQ) ? VEC_IRQ : VEC_EXC;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cause     <= EXC;
      r_irq_pend  <= 1'b0;
      r_cnt       <= '0;
      r_epc_q     <= 32'd0;
      r_pc_target <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_epc_q <= epc;
        r_cause <= w_cause_new;
        r_cnt   <= CNT_W'(DRAIN_CYC - 1);
      end else if (r_state == DRAIN && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // A still-asserted level IRQ re-arms the flag in the same cycle it is
      // consumed.
      r_irq_pend <= irq | (r_irq_pend & ~(w_accept & (w_cause_new == IRQ)));
      if (r_state == VECTOR) begin
        r_pc_target <= w_vec;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    busy        = 1'b0;
    pc_target   = r_pc_target;
    rf_we       = reset & w_wb_hit;
    rf_addr     = wb_addr;
    rf_wdata    = wb_wdata;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          flush       = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (r_cnt == '0) w_state_nxt = LINK;
      end
      LINK: begin
        stall = 1'b1;
        busy  = 1'b1;
        // A retiring WB write keeps the port. The link write waits a cycle.
        if (!w_wb_hit) begin
          rf_we       = 1'b1;
          rf_addr     = (r_cause == IRQ) ? LINK_IRQ : LINK_EXC;
          rf_wdata    = link_value(r_epc_q);
          w_state_nxt = VECTOR;
        end
      end
      VECTOR: begin
        stall       = 1'b1;
        busy        = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = w_vec;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_trap_seq.sv
module tb_cpu_trap_seq;

  localparam int          DRAIN = 2;
  localparam logic [31:0] V_EXC = 32'h8000_0004;
  localparam logic [31:0] V_IRQ = 32'h8000_0008;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irq = 1'b0, exc_req = 1'b0, pc_kernel = 1'b0, wb_we = 1'b0;
  logic [31:0] epc = 32'd0, wb_wdata = 32'd0;
  logic [4:0]  wb_addr = 5'd0;
  logic        rf_we, stall, flush, pc_redirect, busy;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata, pc_target;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  cpu_trap_seq dut (
    .clk(clk), .reset(reset), .irq(irq), .exc_req(exc_req), .epc(epc),
    .pc_kernel(pc_kernel), .wb_we(wb_we), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .stall(stall),
    .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [36:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A trap is tracked by its age in cycles since accept. Ages 1..DRAIN are
  // drain cycles. From age DRAIN+1 the trap waits for a free write port.
  // The cycle after the link write is the redirect.
  bit          m_active, m_linked, m_cause, m_pend;
  int          m_age;
  logic [31:0] m_epc, m_target;

  task automatic model_clear();
    m_active = 0; m_linked = 0; m_cause = 0; m_pend = 0; m_age = 0;
    m_epc = 32'd0; m_target = 32'd0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 0; irq = 1; exc_req = 1; pc_kernel = 0;
    wb_we = 1; wb_addr = 5'd9; wb_wdata = 32'h1234_5678; epc = 32'h40;
    @(negedge clk);
    chk("rst_out", {rf_we, stall, flush, pc_redirect, busy}, 64'd0);
    chk("rst_target", pc_target, 64'd0);
    model_clear();
  endtask

  task automatic step(input logic t_irq, input logic t_exc, input logic [31:0] t_epc,
                      input logic t_kern, input logic t_we, input logic [4:0] t_addr,
                      input logic [31:0] t_data);
    bit acc, vec_ph, link_ph, lnk, hit;
    logic e_we;
    logic [4:0] e_a;
    logic [31:0] e_d, e_tgt;
    @(posedge clk); #1;
    reset = 1; irq = t_irq; exc_req = t_exc; epc = t_epc; pc_kernel = t_kern;
    wb_we = t_we; wb_addr = t_addr; wb_wdata = t_data;
    @(negedge clk);
    hit     = t_we && (t_addr != 5'd0);
    acc     = !m_active && !t_kern && (t_exc || m_pend);
    vec_ph  = m_active && m_linked;
    link_ph = m_active && !m_linked && (m_age > DRAIN);
    lnk     = link_ph && !hit;
    if (lnk) begin
      e_we = 1'b1; e_a = m_cause ? 5'd31 : 5'd26; e_d = m_epc + 32'd4;
    end else begin
      e_we = hit; e_a = t_addr; e_d = t_data;
    end
    e_tgt = vec_ph ? (m_cause ? V_IRQ : V_EXC) : m_target;
    chk("ctrl", {flush, stall, busy, pc_redirect}, {acc, m_active, m_active, vec_ph});
    chk("target", pc_target, e_tgt);
    if (e_we) exp_q.push_back({e_a, e_d});
    chk("rf_we", rf_we, e_we);
    if (rf_we && exp_q.size() > 0) chk("rf_write", {rf_addr, rf_wdata}, exp_q.pop_front());
    exp_q.delete();
    if (acc) begin
      m_active = 1; m_age = 1; m_linked = 0; m_cause = !t_exc; m_epc = t_epc;
    end else if (m_active) begin
      if (vec_ph) begin
        m_active = 0; m_target = e_tgt;
      end else begin
        m_age++;
        if (lnk) m_linked = 1;
      end
    end
    m_pend = t_irq | (m_pend & !(acc && !t_exc));
  endtask

  task automatic idle(input logic k);
    step(1'b0, 1'b0, 32'd0, k, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) idle(1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    apply_reset();

    // Exception from user mode
    step(0, 1, 32'h40, 0, 0, 0, 0);  chk("t1_flush", flush, 1);
    idle_n(2);
    idle(0);  chk("t1_link", {rf_we, rf_addr, rf_wdata}, {1'b1, 5'd26, 32'h44});
    idle(0);  chk("t1_vec", {pc_redirect, pc_target}, {1'b1, V_EXC});

    // One-cycle IRQ
    step(1, 0, 32'h100, 0, 0, 0, 0);
    step(0, 0, 32'h100, 0, 0, 0, 0);  chk("t2_flush", flush, 1);
    idle_n(2);
    idle(0);  chk("t2_link", {rf_we, rf_addr, rf_wdata}, {1'b1, 5'd31, 32'h104});
    idle(0);  chk("t2_vec", {pc_redirect, pc_target}, {1'b1, V_IRQ});

    // Simultaneous exception and IRQ
    step(1, 1, 32'h200, 0, 0, 0, 0);  chk("t3_flush_exc", flush, 1);
    idle_n(2);
    idle(0);  chk("t3_link_exc", {rf_we, rf_addr, rf_wdata}, {1'b1, 5'd26, 32'h204});
    idle(0);  chk("t3_vec_exc", {pc_redirect, pc_target}, {1'b1, V_EXC});
    idle(1); idle(1); idle(1);  chk("t3_kern_hold", flush, 0);
    step(0, 0, 32'h300, 0, 0, 0, 0);  chk("t3_flush_irq", flush, 1);
    idle_n(2);
    idle(0);  chk("t3_link_irq", {rf_we, rf_addr, rf_wdata}, {1'b1, 5'd31, 32'h304});
    idle(0);

    // Kernel mode: exception dropped, IRQ held pending
    step(0, 1, 32'h390, 1, 0, 0, 0);  chk("t4_exc_drop", flush, 0);
    idle(1);  chk("t4_exc_gone", flush, 0);
    step(1, 0, 32'h0, 1, 0, 0, 0);
    idle(1);  chk("t4_irq_wait", flush, 0);
    step(0, 0, 32'h400, 0, 0, 0, 0);  chk("t4_flush", flush, 1);
    idle_n(2);
    idle(0);  chk("t4_link", {rf_we, rf_addr, rf_wdata}, {1'b1, 5'd31, 32'h404});
    idle(0);

    // WB write conflict in LINK
    step(0, 1, 32'h500, 0, 0, 0, 0);
    idle_n(2);
    step(0, 0, 32'h0, 0, 1, 5'd8, 32'hDEAD_BEEF);
    chk("t5_wb_wins", {rf_we, rf_addr, rf_wdata}, {1'b1, 5'd8, 32'hDEAD_BEEF});
    chk("t5_no_redir", {pc_redirect, stall}, {1'b0, 1'b1});
    idle(0);  chk("t5_link", {rf_we, rf_addr, rf_wdata}, {1'b1, 5'd26, 32'h504});
    idle(0);  chk("t5_vec", {pc_redirect, pc_target}, {1'b1, V_EXC});

    // Reset during DRAIN abandons the trap
    step(0, 1, 32'h600, 0, 0, 0, 0);
    idle(0);
    apply_reset();
    idle_n(5);  chk("t6_no_trap", {busy, rf_we}, 0);
    step(1, 0, 32'h700, 0, 0, 0, 0);
    step(0, 0, 32'h700, 0, 0, 0, 0);  chk("t6_flush", flush, 1);
    idle_n(2);
    idle(0);  chk("t6_link", {rf_we, rf_addr, rf_wdata}, {1'b1, 5'd31, 32'h704});
    idle(0);  chk("t6_vec", {pc_redirect, pc_target}, {1'b1, V_IRQ});

    // Write to $0 suppressed
    step(0, 0, 32'h0, 0, 1, 5'd0, 32'h1234);  chk("t7_r0", rf_we, 0);

    // Link value wraps
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    idle_n(2);
    idle(0);  chk("t8_wrap", {rf_we, rf_addr, rf_wdata}, {1'b1, 5'd26, 32'h0});
    idle(0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] a;
      logic [31:0] e;
      if ($urandom_range(0, 399) == 0) apply_reset();
      a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      e = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 14) == 0), e,
           ($urandom_range(0, 3) == 0), $urandom_range(0, 1), a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
